// File: rtl/axis_slave_sink.sv
// axis_slave_sink
// AXI4-Stream slave endpoint. TREADY backpressure is programmable: always
// ready, a fixed hold-off after each beat, pseudo-random, or stopped.
// Every accepted beat is captured into a show-ahead FIFO. Packet and beat
// counters and a sticky strobe/keep protocol-error flag are also kept.
// TREADY is registered and is held low whenever the FIFO would be full
// after the current cycle, so the FIFO is never written while full.

module axis_slave_sink #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4,
    parameter int TUSER_WIDTH = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [TDATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0]       s_axis_tstrb,
    input  logic [TDATA_WIDTH/8-1:0]       s_axis_tkeep,
    input  logic                           s_axis_tlast,
    input  logic [TID_WIDTH-1:0]           s_axis_tid,
    input  logic [TDEST_WIDTH-1:0]         s_axis_tdest,
    input  logic [TUSER_WIDTH-1:0]         s_axis_tuser,
    input  logic [1:0]                     cfg_mode,
    input  logic [7:0]                     cfg_delay,
    input  logic                           cfg_wait_valid,
    input  logic [15:0]                    cfg_seed,
    input  logic                           cfg_load,
    input  logic                           cap_rd_en,
    output logic                           cap_rd_valid,
    output logic [TUSER_WIDTH+TDEST_WIDTH+TID_WIDTH+1+2*(TDATA_WIDTH/8)+TDATA_WIDTH-1:0] cap_rd_data,
    output logic [$clog2(FIFO_DEPTH):0]    cap_level,
    output logic [31:0]                    beat_count,
    output logic [31:0]                    pkt_count,
    output logic                           err_strb
);

    localparam int KW    = TDATA_WIDTH / 8;
    localparam int CAP_W = TUSER_WIDTH + TDEST_WIDTH + TID_WIDTH + 1 + 2 * KW + TDATA_WIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    localparam logic [AW-1:0]    PTR_ONE   = AW'(1'b1);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1'b1);
    localparam logic [LVL_W-1:0] LVL_ZERO  = LVL_W'(1'b0);
    localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0]  MODE_ALWAYS = 2'd0;
    localparam logic [1:0]  MODE_DELAY  = 2'd1;
    localparam logic [1:0]  MODE_RANDOM = 2'd2;
    localparam logic [1:0]  MODE_STOP   = 2'd3;
    localparam logic [15:0] LFSR_INIT   = 16'hACE1;

    // Hold-off sequencer used only in DELAY mode.
    typedef enum logic [1:0] {
        ST_RDY   = 2'd0,
        ST_WAITV = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // One step of the x^16+x^14+x^13+x^11+1 Galois LFSR (right-shifting).
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n = n ^ 16'hB400;
        end else begin
            n = n;
        end
        return n;
    endfunction

    // State registers and their next-state values.
    logic              tready_q, tready_d;
    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [31:0]       beat_q, beat_d;
    logic [31:0]       pkt_q, pkt_d;
    logic              err_q, err_d;
    logic [CAP_W-1:0]  mem_q [FIFO_DEPTH];

    // Combinational helpers.
    logic              accept_s;
    logic              pop_s;
    logic              gate_s;
    logic              beat_bad_s;
    logic [CAP_W-1:0]  wr_data_s;

    // Handshake decode: a beat transfers on valid&ready, a pop needs a non-empty FIFO.
    always_comb begin
        accept_s   = s_axis_tvalid & tready_q;
        pop_s      = cap_rd_en & (level_q != LVL_ZERO);
        beat_bad_s = |(s_axis_tstrb & ~s_axis_tkeep);
        wr_data_s  = {s_axis_tuser, s_axis_tdest, s_axis_tid, s_axis_tlast,
                      s_axis_tkeep, s_axis_tstrb, s_axis_tdata};
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({accept_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // DELAY-mode sequencer next state; any other mode parks it in RDY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cfg_mode == MODE_DELAY) begin
            case (state_q)
                ST_RDY: begin
                    if (accept_s) begin
                        if (cfg_delay == 8'd0) begin
                            state_d = ST_RDY;
                        end else if (cfg_wait_valid) begin
                            state_d = ST_WAITV;
                        end else begin
                            cnt_d   = cfg_delay - 8'd1;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        state_d = ST_RDY;
                    end
                end
                ST_WAITV: begin
                    if (s_axis_tvalid) begin
                        if (cfg_delay == 8'd0) begin
                            state_d = ST_RDY;
                        end else begin
                            cnt_d   = cfg_delay - 8'd1;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        state_d = ST_WAITV;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_RDY;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_RDY;
                end
            endcase
        end else begin
            state_d = ST_RDY;
        end
    end

    // Ready gate per mode, qualified so that next cycle's write cannot overflow the FIFO.
    always_comb begin
        gate_s = 1'b0;
        case (cfg_mode)
            MODE_ALWAYS: gate_s = 1'b1;
            MODE_DELAY:  gate_s = (state_d == ST_RDY);
            MODE_RANDOM: gate_s = lfsr_q[0];
            MODE_STOP:   gate_s = 1'b0;
            default:     gate_s = 1'b0;
        endcase
        tready_d = gate_s & (level_d < LVL_DEPTH);
    end

    // LFSR free-runs every cycle; cfg_load reseeds it, with zero mapped to the default seed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (cfg_load) begin
            if (cfg_seed == 16'h0000) begin
                lfsr_d = LFSR_INIT;
            end else begin
                lfsr_d = cfg_seed;
            end
        end else begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // Statistics: cfg_load wins over an accept in the same cycle.
    always_comb begin
        beat_d = beat_q;
        pkt_d  = pkt_q;
        err_d  = err_q;
        if (cfg_load) begin
            beat_d = 32'd0;
            pkt_d  = 32'd0;
            err_d  = 1'b0;
        end else if (accept_s) begin
            beat_d = beat_q + 32'd1;
            if (s_axis_tlast) begin
                pkt_d = pkt_q + 32'd1;
            end else begin
                pkt_d = pkt_q;
            end
            err_d = err_q | beat_bad_s;
        end else begin
            beat_d = beat_q;
            pkt_d  = pkt_q;
            err_d  = err_q;
        end
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tready_q <= 1'b0;
            state_q  <= ST_RDY;
            cnt_q    <= 8'd0;
            lfsr_q   <= LFSR_INIT;
            level_q  <= LVL_ZERO;
            wr_ptr_q <= AW'(1'b0);
            rd_ptr_q <= AW'(1'b0);
            beat_q   <= 32'd0;
            pkt_q    <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            tready_q <= tready_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
            pkt_q    <= pkt_d;
            err_q    <= err_d;
        end
    end

    // Capture storage; contents are meaningless when empty, so it is not reset.
    always_ff @(posedge ACLK) begin
        if (accept_s) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

    assign s_axis_tready = tready_q;
    assign cap_rd_valid  = (level_q != LVL_ZERO);
    assign cap_rd_data   = mem_q[rd_ptr_q];
    assign cap_level     = level_q;
    assign beat_count    = beat_q;
    assign pkt_count     = pkt_q;
    assign err_strb      = err_q;

endmodule

// File: tb/tb_axis_slave_sink.sv
// Bench for axis_slave_sink: randomized AXI4-Stream source, cycle-level
// reference model of ready/occupancy/counters, and a scoreboard of captured
// beats that a separate monitor checks against the FIFO output on each pop.

module tb_axis_slave_sink;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int IDW   = 4;
    localparam int DSW   = 4;
    localparam int UW    = 1;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CW    = UW + DSW + IDW + 1 + 2 * KW + DW;

    logic            ACLK;
    logic            ARESETn;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tstrb;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tlast;
    logic [IDW-1:0]  s_axis_tid;
    logic [DSW-1:0]  s_axis_tdest;
    logic [UW-1:0]   s_axis_tuser;
    logic [1:0]      cfg_mode;
    logic [7:0]      cfg_delay;
    logic            cfg_wait_valid;
    logic [15:0]     cfg_seed;
    logic            cfg_load;
    logic            cap_rd_en;
    logic            cap_rd_valid;
    logic [CW-1:0]   cap_rd_data;
    logic [LW-1:0]   cap_level;
    logic [31:0]     beat_count;
    logic [31:0]     pkt_count;
    logic            err_strb;

    axis_slave_sink #(
        .TDATA_WIDTH (DW),
        .TID_WIDTH   (IDW),
        .TDEST_WIDTH (DSW),
        .TUSER_WIDTH (UW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .ACLK           (ACLK),
        .ARESETn        (ARESETn),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tstrb   (s_axis_tstrb),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tid     (s_axis_tid),
        .s_axis_tdest   (s_axis_tdest),
        .s_axis_tuser   (s_axis_tuser),
        .cfg_mode       (cfg_mode),
        .cfg_delay      (cfg_delay),
        .cfg_wait_valid (cfg_wait_valid),
        .cfg_seed       (cfg_seed),
        .cfg_load       (cfg_load),
        .cap_rd_en      (cap_rd_en),
        .cap_rd_valid   (cap_rd_valid),
        .cap_rd_data    (cap_rd_data),
        .cap_level      (cap_level),
        .beat_count     (beat_count),
        .pkt_count      (pkt_count),
        .err_strb       (err_strb)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit             m_tready  = 1'b0;
    int             m_level   = 0;
    logic [31:0]    m_beats   = 32'd0;
    logic [31:0]    m_pkts    = 32'd0;
    bit             m_err     = 1'b0;
    logic [15:0]    m_lfsr    = 16'hACE1;
    int             cyc       = 0;
    int             d_release = 0;   // first cycle DELAY mode may be ready again
    bit             d_waiting = 1'b0; // DELAY hold-off waiting for tvalid
    bit             m_acc     = 1'b0; // a beat was taken at the last edge
    logic [CW-1:0]  exp_q[$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        if (x[0]) return (x >> 1) ^ 16'hB400;
        else      return x >> 1;
    endfunction

    always @(posedge ACLK) begin : model
        bit acc;
        bit pop;
        bit gate;
        if (!ARESETn) begin
            m_tready  = 1'b0;
            m_level   = 0;
            m_beats   = 32'd0;
            m_pkts    = 32'd0;
            m_err     = 1'b0;
            m_lfsr    = 16'hACE1;
            d_release = 0;
            d_waiting = 1'b0;
            m_acc     = 1'b0;
            exp_q.delete();
        end else begin
            acc   = s_axis_tvalid && m_tready;
            pop   = cap_rd_en && (m_level > 0);
            m_acc = acc;
            if (acc) begin
                exp_q.push_back({s_axis_tuser, s_axis_tdest, s_axis_tid, s_axis_tlast,
                                 s_axis_tkeep, s_axis_tstrb, s_axis_tdata});
                m_beats = m_beats + 32'd1;
                if (s_axis_tlast) m_pkts = m_pkts + 32'd1;
                if ((s_axis_tstrb & ~s_axis_tkeep) != '0) m_err = 1'b1;
            end
            if (cfg_load) begin
                m_beats = 32'd0;
                m_pkts  = 32'd0;
                m_err   = 1'b0;
            end
            gate = 1'b0;
            if (cfg_mode == 2'd1) begin
                if (d_waiting) begin
                    if (s_axis_tvalid) begin
                        d_waiting = 1'b0;
                        d_release = cyc + int'(cfg_delay) + 1;
                    end
                end else if (acc && cfg_delay != 8'd0) begin
                    if (cfg_wait_valid) d_waiting = 1'b1;
                    else                d_release = cyc + int'(cfg_delay) + 1;
                end
                gate = !d_waiting && (cyc + 1 >= d_release);
            end else begin
                d_waiting = 1'b0;
                d_release = 0;
                gate = (cfg_mode == 2'd0) ? 1'b1 : (cfg_mode == 2'd2) ? m_lfsr[0] : 1'b0;
            end
            if (cfg_load) m_lfsr = (cfg_seed == 16'h0) ? 16'hACE1 : cfg_seed;
            else          m_lfsr = lfsr_next(m_lfsr);
            m_level  = m_level + int'(acc) - int'(pop);
            m_tready = gate && (m_level < DEPTH);
            cyc++;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge ACLK) begin : monitor
        logic [CW-1:0] e;
        if (ARESETn) begin
            chk("tready",     64'(s_axis_tready), 64'(m_tready));
            chk("cap_level",  64'(cap_level),     64'(m_level));
            chk("rd_valid",   64'(cap_rd_valid),  64'(m_level > 0));
            chk("beat_count", 64'(beat_count),    64'(m_beats));
            chk("pkt_count",  64'(pkt_count),     64'(m_pkts));
            chk("err_strb",   64'(err_strb),      64'(m_err));
            if (cap_rd_en && cap_rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_data: DUT popped %0h, scoreboard empty", cap_rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", 64'(cap_rd_data), 64'(e));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] data_ctr = 32'd0;
    int          beat_idx = 0;
    bit          err_next = 1'b0;

    // ncyc cycles; vprob/rprob in percent; gap = idle cycles after each accept.
    task automatic run(input int ncyc, input int vprob, input int rprob, input int gap,
                       input int last_every, input int max_beats);
        int gap_cnt = 0;
        int issued  = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge ACLK);
            #1;
            cfg_load = 1'b0;
            if (m_acc) gap_cnt = gap;
            if (s_axis_tvalid && !m_acc) begin
                s_axis_tvalid = 1'b1;
            end else if (gap_cnt > 0) begin
                s_axis_tvalid = 1'b0;
                gap_cnt--;
            end else if (issued < max_beats && int'($urandom_range(99)) < vprob) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = data_ctr;
                data_ctr      = data_ctr + 32'd1;
                s_axis_tlast  = ((beat_idx % last_every) == last_every - 1);
                beat_idx++;
                s_axis_tid    = IDW'($urandom_range(15));
                s_axis_tdest  = DSW'($urandom_range(15));
                s_axis_tuser  = UW'($urandom_range(1));
                if (err_next) begin
                    s_axis_tkeep = 4'b0111;
                    s_axis_tstrb = 4'b1001;
                    err_next     = 1'b0;
                end else begin
                    s_axis_tkeep = KW'($urandom_range(15));
                    s_axis_tstrb = s_axis_tkeep & KW'($urandom_range(15));
                end
                issued++;
            end else begin
                s_axis_tvalid = 1'b0;
            end
            cap_rd_en = (int'($urandom_range(99)) < rprob);
        end
    endtask

    initial begin
        ARESETn = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; s_axis_tid = '0; s_axis_tdest = '0; s_axis_tuser = '0;
        cfg_mode = 2'd0; cfg_delay = 8'd0; cfg_wait_valid = 1'b0; cfg_seed = 16'h0;
        cfg_load = 1'b0; cap_rd_en = 1'b0;

        // reset values
        #2 ARESETn = 1'b0;
        #1;
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_level",  64'(cap_level),     64'd0);
        chk("rst_valid",  64'(cap_rd_valid),  64'd0);
        chk("rst_beats",  64'(beat_count),    64'd0);
        chk("rst_pkts",   64'(pkt_count),     64'd0);
        chk("rst_err",    64'(err_strb),      64'd0);
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;

        // ALWAYS: one 5-beat packet 0x10..0x14, then pop it back in order
        data_ctr = 32'h10; beat_idx = 0;
        run(10, 100, 0, 0, 5, 5);
        chk("pkt5_beats", 64'(beat_count), 64'd5);
        chk("pkt5_pkts",  64'(pkt_count),  64'd1);
        run(8, 0, 100, 0, 5, 0);
        chk("pkt5_drained", 64'(cap_level), 64'd0);

        // ALWAYS: 20 beats without popping fill exactly DEPTH entries
        run(25, 100, 0, 0, 1, 20);
        chk("full_level",  64'(cap_level),     64'(DEPTH));
        chk("full_beats",  64'(beat_count),    64'(5 + DEPTH));
        chk("full_tready", 64'(s_axis_tready), 64'd0);
        run(1, 100, 100, 0, 1, 0);
        run(4, 100, 0, 0, 1, 0);
        chk("refill_beats", 64'(beat_count), 64'(6 + DEPTH));
        run(30, 0, 100, 0, 1, 0);

        // DELAY 3 with tvalid held: one beat every four cycles
        cfg_mode = 2'd1; cfg_delay = 8'd3; cfg_wait_valid = 1'b0;
        run(3, 0, 100, 0, 1, 0);
        cfg_load = 1'b1;
        run(1, 0, 100, 0, 1, 0);
        run(14, 100, 100, 0, 1, 1000);
        chk("delay3_beats", 64'(beat_count), 64'd4);

        // DELAY 2 with wait-for-valid, 5-cycle source gaps
        cfg_mode = 2'd0;
        run(3, 0, 100, 0, 1, 0);
        cfg_mode = 2'd1; cfg_delay = 8'd2; cfg_wait_valid = 1'b1;
        run(40, 100, 100, 5, 3, 1000);

        // strobe/keep violation is sticky until cfg_load
        cfg_mode = 2'd0;
        run(3, 0, 100, 0, 1, 0);
        err_next = 1'b1;
        run(4, 100, 100, 0, 1, 1);
        chk("err_set", 64'(err_strb), 64'd1);
        run(3, 0, 100, 0, 1, 0);
        chk("err_sticky", 64'(err_strb), 64'd1);
        cfg_load = 1'b1;
        run(1, 0, 100, 0, 1, 0);
        chk("load_err",   64'(err_strb),   64'd0);
        chk("load_beats", 64'(beat_count), 64'd0);
        chk("load_pkts",  64'(pkt_count),  64'd0);

        // RANDOM with seed 1, tvalid always high, 64 cycles
        cfg_mode = 2'd2; cfg_seed = 16'h0001; cfg_load = 1'b1;
        run(64, 100, 100, 0, 4, 1000);

        // randomized segments across all modes
        for (int s = 0; s < 25; s++) begin
            cfg_mode       = 2'd0;
            cfg_delay      = 8'($urandom_range(4));
            cfg_wait_valid = 1'($urandom_range(1));
            run(1, 50, 50, 0, 1, 1000);
            cfg_mode = 2'($urandom_range(3));
            if ($urandom_range(2) == 0) begin
                cfg_seed = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom_range(65535));
                cfg_load = 1'b1;
            end
            run(int'($urandom_range(60, 20)), int'($urandom_range(100, 30)),
                int'($urandom_range(100)), int'($urandom_range(3)),
                int'($urandom_range(6, 1)), 1000);
        end

        // asynchronous reset in the middle of a packet
        cfg_mode = 2'd0;
        run(6, 100, 40, 0, 8, 1000);
        #2 ARESETn = 1'b0;
        #1;
        chk("midrst_tready", 64'(s_axis_tready), 64'd0);
        chk("midrst_level",  64'(cap_level),     64'd0);
        chk("midrst_valid",  64'(cap_rd_valid),  64'd0);
        chk("midrst_beats",  64'(beat_count),    64'd0);
        s_axis_tvalid = 1'b0;
        cap_rd_en     = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        run(20, 100, 100, 0, 3, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
